// File: rtl/output_display_ctrl_if.sv
// +----------------------------------------------------------------------+
// | output_display_ctrl_if : datapath-to-display signal bundle            |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

interface output_display_ctrl_if #(
  parameter int DATA_W     = 10,
  parameter int NUM_DIGITS = 3,
  parameter int TIME_W     = 2
);
  logic [DATA_W-1:0]       bus;
  logic [DATA_W-1:0]       reg_data;
  logic [TIME_W-1:0]       step_time;
  logic                    peekb;
  logic                    hold;
  logic                    done;
  logic [DATA_W-1:0]       led_b;
  logic [7*NUM_DIGITS-1:0] dhex;
  logic [6:0]              thex;
  logic                    led_d;
  logic                    held;

  modport master (
    output bus, reg_data, step_time, peekb, hold, done,
    input  led_b, dhex, thex, led_d, held
  );

  modport slave (
    input  bus, reg_data, step_time, peekb, hold, done,
    output led_b, dhex, thex, led_d, held
  );
endinterface

`default_nettype wire

// File: rtl/output_display_ctrl.sv
// +----------------------------------------------------------------------+
// | output_display_ctrl : registered front-panel select/freeze/hex stage  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module output_display_ctrl #(
  parameter int DATA_W     = 10,
  parameter int NUM_DIGITS = 3,
  parameter int TIME_W     = 2,
  parameter int DONE_HOLD  = 8,
  parameter int LZ_BLANK   = 0
) (
  input  wire logic             clock,
  input  wire logic             resetn,
  output_display_ctrl_if.slave  io
);

  typedef enum logic [0:0] {
    LIVE = 1'b0,
    HELD = 1'b1
  } state_t;

  localparam int              PAD_W       = 4 * NUM_DIGITS;
  localparam int              CNT_W       = $clog2(DONE_HOLD + 1);
  localparam logic [CNT_W-1:0] C_HOLD_LOAD = CNT_W'(DONE_HOLD);
  localparam logic [6:0]      C_GLYPH_ZERO = 7'b1000000;
  localparam logic [6:0]      C_BLANK      = 7'h7F;

  state_t                  r_state;
  logic [DATA_W-1:0]       r_disp_val;
  logic [CNT_W-1:0]        r_done_cnt;
  logic [DATA_W-1:0]       r_led_b;
  logic [7*NUM_DIGITS-1:0] r_dhex;
  logic [6:0]              r_thex;
  logic                    r_led_d;
  logic                    r_held;

  logic [DATA_W-1:0]       w_sel;
  logic                    w_load;
  logic [DATA_W-1:0]       w_disp_next;
  logic [CNT_W-1:0]        w_cnt_next;
  logic [7*NUM_DIGITS-1:0] w_dhex_next;

  // Active-low {g,f,e,d,c,b,a}; b and d use lower-case shapes.
  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  // Frozen only while already HELD and HOLD still high; release loads on the same edge.
  assign w_sel       = io.peekb ? io.bus : io.reg_data;
  assign w_load      = (r_state == LIVE) || !io.hold;
  assign w_disp_next = w_load ? w_sel : r_disp_val;

  assign w_cnt_next = io.done             ? C_HOLD_LOAD :
                      (r_done_cnt != '0)  ? r_done_cnt - CNT_W'(1) :
                                            r_done_cnt;

  always_comb begin
    logic [PAD_W-1:0] pad;
    logic [3:0]       nib;
    logic             seen;
    pad         = PAD_W'(w_disp_next);
    seen        = 1'b0;
    w_dhex_next = '0;
    // Walk from the most significant digit so "seen" marks any nonzero digit at or above i.
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nib  = pad[4*i +: 4];
      seen = seen | (nib != 4'h0);
      if ((LZ_BLANK != 0) && (i != 0) && !seen) begin
        w_dhex_next[7*i +: 7] = C_BLANK;
      end else begin
        w_dhex_next[7*i +: 7] = hex_glyph(nib);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state    <= LIVE;
      r_held     <= 1'b0;
      r_disp_val <= '0;
      r_done_cnt <= '0;
      r_led_d    <= 1'b0;
      r_led_b    <= '0;
      r_dhex     <= {NUM_DIGITS{C_GLYPH_ZERO}};
      r_thex     <= C_GLYPH_ZERO;
    end else begin
      case (r_state)
        LIVE: begin
          if (io.hold) begin
            r_state <= HELD;
            r_held  <= 1'b1;
          end
        end
        HELD: begin
          if (!io.hold) begin
            r_state <= LIVE;
            r_held  <= 1'b0;
          end
        end
        default: begin
          r_state <= LIVE;
          r_held  <= 1'b0;
        end
      endcase
      r_disp_val <= w_disp_next;
      r_dhex     <= w_dhex_next;
      r_done_cnt <= w_cnt_next;
      r_led_d    <= (w_cnt_next != '0);
      r_led_b    <= io.bus;
      r_thex     <= hex_glyph(4'(io.step_time));
    end
  end

  assign io.led_b = r_led_b;
  assign io.dhex  = r_dhex;
  assign io.thex  = r_thex;
  assign io.led_d = r_led_d;
  assign io.held  = r_held;

endmodule

`default_nettype wire

// File: tb/tb_output_display_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_output_display_ctrl : directed checks of output_display_ctrl       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_output_display_ctrl;

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G5 = 7'b0010010;
  localparam logic [6:0] G7 = 7'b1111000;
  localparam logic [6:0] GA = 7'b0001000;
  localparam logic [6:0] GB = 7'b0000011;
  localparam logic [6:0] GC = 7'b1000110;
  localparam logic [6:0] GF = 7'b0001110;
  localparam logic [6:0] BL = 7'h7F;

  logic clock;
  logic resetn;
  int   checks;
  int   failures;

  output_display_ctrl_if #(.DATA_W(10), .NUM_DIGITS(3), .TIME_W(2)) if0 ();
  output_display_ctrl_if #(.DATA_W(10), .NUM_DIGITS(3), .TIME_W(2)) if1 ();

  // The blanking instance sees exactly the same inputs.
  assign if1.bus       = if0.bus;
  assign if1.reg_data  = if0.reg_data;
  assign if1.step_time = if0.step_time;
  assign if1.peekb     = if0.peekb;
  assign if1.hold      = if0.hold;
  assign if1.done      = if0.done;

  output_display_ctrl #(
    .DATA_W(10), .NUM_DIGITS(3), .TIME_W(2), .DONE_HOLD(8), .LZ_BLANK(0)
  ) dut0 (
    .clock  (clock),
    .resetn (resetn),
    .io     (if0.slave)
  );

  output_display_ctrl #(
    .DATA_W(10), .NUM_DIGITS(3), .TIME_W(2), .DONE_HOLD(8), .LZ_BLANK(1)
  ) dut1 (
    .clock  (clock),
    .resetn (resetn),
    .io     (if1.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [6:0] tglyph [4];
    tglyph[0] = G0; tglyph[1] = G1; tglyph[2] = G2; tglyph[3] = G3;
    checks   = 0;
    failures = 0;

    // Reset overrides active inputs.
    resetn        = 1'b0;
    if0.bus       = 10'h3FF;
    if0.reg_data  = 10'h000;
    if0.step_time = 2'd0;
    if0.peekb     = 1'b1;
    if0.hold      = 1'b0;
    if0.done      = 1'b1;
    tick();
    tick();
    chk("rst_dhex",   32'(if0.dhex),  32'({G0, G0, G0}));
    chk("rst_dhex_lz", 32'(if1.dhex), 32'({G0, G0, G0}));
    chk("rst_led_d",  32'(if0.led_d), 32'd0);
    chk("rst_held",   32'(if0.held),  32'd0);
    chk("rst_led_b",  32'(if0.led_b), 32'd0);
    chk("rst_thex",   32'(if0.thex),  32'(G0));

    // Source select.
    resetn       = 1'b1;
    if0.done     = 1'b0;
    if0.bus      = 10'h2A5;
    if0.reg_data = 10'h13C;
    tick();
    chk("sel_bus",   32'(if0.dhex),  32'({G2, GA, G5}));
    chk("sel_led_b", 32'(if0.led_b), 32'h2A5);
    if0.peekb = 1'b0;
    tick();
    chk("sel_reg",    32'(if0.dhex), 32'({G1, G3, GC}));
    chk("sel_reg_lz", 32'(if1.dhex), 32'({G1, G3, GC}));

    // Freeze.
    if0.bus   = 10'h100;
    if0.peekb = 1'b1;
    if0.hold  = 1'b1;
    tick();
    chk("frz_cap",  32'(if0.dhex), 32'({G1, G0, G0}));
    chk("frz_held", 32'(if0.held), 32'd1);
    if0.bus   = 10'h3FF;
    if0.peekb = 1'b0;
    tick();
    chk("frz_keep0", 32'(if0.dhex),  32'({G1, G0, G0}));
    chk("frz_led_b", 32'(if0.led_b), 32'h3FF);
    if0.peekb = 1'b1;
    tick();
    chk("frz_keep1", 32'(if0.dhex), 32'({G1, G0, G0}));
    chk("frz_held1", 32'(if0.held), 32'd1);
    if0.hold = 1'b0;
    tick();
    chk("frz_rel",      32'(if0.dhex), 32'({G3, GF, GF}));
    chk("frz_rel_held", 32'(if0.held), 32'd0);

    // Single DONE pulse: lit for exactly 8 cycles.
    chk("str_idle", 32'(if0.led_d), 32'd0);
    if0.done = 1'b1;
    tick();
    if0.done = 1'b0;
    chk("str_c1", 32'(if0.led_d), 32'd1);
    for (int k = 2; k <= 8; k++) begin
      tick();
      chk($sformatf("str_c%0d", k), 32'(if0.led_d), 32'd1);
    end
    tick();
    chk("str_off", 32'(if0.led_d), 32'd0);

    // Retrigger at the fifth lit cycle.
    if0.done = 1'b1;
    tick();
    if0.done = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      tick();
      chk($sformatf("rtg_a%0d", k), 32'(if0.led_d), 32'd1);
    end
    if0.done = 1'b1;
    tick();
    if0.done = 1'b0;
    chk("rtg_b1", 32'(if0.led_d), 32'd1);
    for (int k = 2; k <= 8; k++) begin
      tick();
      chk($sformatf("rtg_b%0d", k), 32'(if0.led_d), 32'd1);
    end
    tick();
    chk("rtg_off", 32'(if0.led_d), 32'd0);

    // Leading-zero blanking.
    if0.peekb    = 1'b0;
    if0.reg_data = 10'h007;
    tick();
    chk("lz_007",   32'(if1.dhex), 32'({BL, BL, G7}));
    chk("nolz_007", 32'(if0.dhex), 32'({G0, G0, G7}));
    if0.reg_data = 10'h200;
    tick();
    chk("lz_200", 32'(if1.dhex), 32'({G2, G0, G0}));
    if0.reg_data = 10'h030;
    tick();
    chk("lz_030", 32'(if1.dhex), 32'({BL, G3, G0}));
    if0.reg_data = 10'h000;
    tick();
    chk("lz_000", 32'(if1.dhex), 32'({BL, BL, G0}));

    // TIME digit sweep.
    for (int t = 0; t < 4; t++) begin
      if0.step_time = 2'(t);
      tick();
      chk($sformatf("thex_%0d", t), 32'(if0.thex), 32'(tglyph[t]));
    end

    // Reset while frozen and stretching.
    if0.peekb = 1'b1;
    if0.bus   = 10'h2A5;
    if0.hold  = 1'b1;
    if0.done  = 1'b1;
    tick();
    if0.done = 1'b0;
    chk("mid_held",  32'(if0.held),  32'd1);
    chk("mid_led_d", 32'(if0.led_d), 32'd1);
    resetn = 1'b0;
    tick();
    chk("mid_rst_dhex",  32'(if0.dhex),  32'({G0, G0, G0}));
    chk("mid_rst_held",  32'(if0.held),  32'd0);
    chk("mid_rst_led_d", 32'(if0.led_d), 32'd0);
    chk("mid_rst_led_b", 32'(if0.led_b), 32'd0);
    chk("mid_rst_thex",  32'(if0.thex),  32'(G0));
    resetn   = 1'b1;
    if0.hold = 1'b0;
    if0.bus  = 10'h0AB;
    tick();
    chk("post_rst_live", 32'(if0.dhex),  32'({G0, GA, GB}));
    chk("post_rst_lz",   32'(if1.dhex),  32'({BL, GA, GB}));
    chk("post_rst_cnt",  32'(if0.led_d), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
